state_backtrace: RTL and testbench
==================================

STATE_BACKTRACE -- requirements
Module: state_backtrace

Interface
REQ-001 Parameter MAX_DEPTH, default 2048, maximum entries emitted per walk before forced termination.
REQ-002 Parameter ROOT_ADDR, default 11'h7FF, prev-address value that marks a chain root.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a walk; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 seq_re  output  1  sequential-read enable to the state regfile.
REQ-008 seq_r_data  input  16  newest state word, combinational from the regfile.
REQ-009 out_r_addr  input  12  address of seq_r_data; 12'hFFF means the regfile is empty.
REQ-010 ran_re  output  1  random-read enable to the state regfile.
REQ-011 ran_r_addr  output  12  random-read address.
REQ-012 ran_r_data  input  16  random-read word, combinational from the regfile.
REQ-013 bt_valid / bt_ready  output / input  1 / 1  entry stream handshake.
REQ-014 bt_pos  output  4  call position, word[15:12].
REQ-015 bt_addr  output  12  regfile address of the emitted entry.
REQ-016 bt_end  output  1  end flag, word[0].
REQ-017 bt_last  output  1  emitted entry is the final one of the walk.
REQ-018 done  output  1  one-cycle pulse at walk completion.
REQ-019 err  output  1  walk terminated abnormally; held until the next start.
REQ-020 depth  output  12  number of entries accepted in the current or last walk.

Function
REQ-021 State word layout SHALL be: [15:12] call position, [11:1] previous-entry address, [0] end flag.
REQ-022 FSM states SHALL be IDLE, SEQ, EMIT, FETCH, FIN.
REQ-023 IDLE: on start=1, clear depth and err and go to SEQ; otherwise stay.
REQ-024 SEQ: drive seq_re=1 for exactly one cycle and register seq_r_data and out_r_addr at the closing edge.
REQ-025 SEQ when out_r_addr==12'hFFF: set err=1 and go to FIN without emitting anything.
REQ-026 SEQ otherwise: go to EMIT.
REQ-027 FETCH: drive ran_re=1 with ran_r_addr = {1'b0, registered prev field} for one cycle, register ran_r_data and that address, then go to EMIT.
REQ-028 ran_r_addr SHALL hold its last value when ran_re=0; seq_re and ran_re SHALL never both be high.
REQ-029 EMIT: hold bt_valid=1 with bt_pos, bt_addr, bt_end and bt_last stable from registers until bt_ready=1; outputs are undefined-free and constant while stalled.
REQ-030 In EMIT, bt_last SHALL be 1 if any of the following holds:
- prev field == ROOT_ADDR;
- prev field >= bt_addr (a non-backward link);
- depth+1 == MAX_DEPTH.
REQ-031 On the cycle bt_valid&bt_ready fires, increment depth. Go to FIN if bt_last=1, else go to FETCH.
REQ-032 On the accepting cycle of REQ-031, set err=1 if bt_last was caused by a non-backward link or by the depth limit rather than by ROOT_ADDR.
REQ-033 FIN: pulse done=1 for one cycle, then go to IDLE.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 Latency SHALL be as follows:
- start accepted at edge N, so the FSM is in SEQ from N.
- bt_valid is first high after edge N+1.
- Each further entry appears 2 cycles after the previous handshake.
REQ-036 bt_valid SHALL be 0 in all states except EMIT.

Reset
REQ-037 rst_n=0 SHALL, asynchronously and at any point mid-walk, force the following, and the walk is abandoned:
- state=IDLE;
- busy, seq_re, ran_re, bt_valid, bt_last, done and err = 0;
- ran_r_addr, bt_pos, bt_addr, bt_end and depth = 0.
REQ-038 After rst_n rises, the block SHALL ignore all inputs except start.

Verification
REQ-039 Empty regfile: out_r_addr=12'hFFF, start -> no bt_valid, done pulse, err=1, depth=0.
REQ-040 Chain 0<-1<-2, with entry 0 prev=7FF and entry 2 word 16'h5003, bt_ready=1 -> emits addr 2 (pos 5, end 1), then 1, then 0 with bt_last=1 -> done, err=0, depth=3.
REQ-041 Backpressure: bt_ready low for 5 cycles on the first entry -> bt_valid and all payload held constant, no FETCH issued, sequence otherwise identical.
REQ-042 Bad link: entry 3 prev=3 -> single emit with bt_last=1, err=1, depth=1.
REQ-043 MAX_DEPTH=2 on a 4-deep chain -> second emit has bt_last=1, err=1, depth=2.
REQ-044 Reset asserted during FETCH -> all outputs zero immediately; next start restarts from SEQ.

Source files
------------

// File: rtl/state_backtrace.sv
// Walks a linked chain of state words backwards from the newest regfile
// entry to its root and streams one entry per handshake.
module state_backtrace #(
  parameter int unsigned MAX_DEPTH = 2048,
  parameter logic [10:0] ROOT_ADDR = 11'h7FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        busy_o,
  output logic        seq_re_o,
  input  logic [15:0] seq_r_data_i,
  input  logic [11:0] out_r_addr_i,
  output logic        ran_re_o,
  output logic [11:0] ran_r_addr_o,
  input  logic [15:0] ran_r_data_i,
  output logic        bt_valid_o,
  input  logic        bt_ready_i,
  output logic [3:0]  bt_pos_o,
  output logic [11:0] bt_addr_o,
  output logic        bt_end_o,
  output logic        bt_last_o,
  output logic        done_o,
  output logic        err_o,
  output logic [11:0] depth_o
);

  typedef enum logic [2:0] {StIdle, StSeq, StEmit, StFetch, StFin} state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q;
  logic [11:0] addr_q;
  logic [11:0] depth_q;
  logic        err_q;
  logic [11:0] ran_addr_q;

  logic [10:0] prev;
  logic [11:0] prev_addr;
  logic [31:0] depth_next;
  logic        is_root;
  logic        fwd_link;
  logic        depth_hit;
  logic        last_c;
  logic        seq_empty;

  // Decode the held entry: link target and termination reasons.
  always_comb begin
    prev       = word_q[11:1];
    prev_addr  = {1'b0, prev};
    depth_next = 32'(depth_q) + 32'd1;
    is_root    = (prev == ROOT_ADDR);
    // A link that does not point strictly older is treated as corruption.
    fwd_link   = (prev_addr >= addr_q);
    depth_hit  = (depth_next == 32'(MAX_DEPTH));
    last_c     = is_root | fwd_link | depth_hit;
    seq_empty  = (out_r_addr_i == 12'hFFF);
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_d      = state_q;
    busy_o       = (state_q != StIdle);
    seq_re_o     = 1'b0;
    ran_re_o     = 1'b0;
    ran_r_addr_o = ran_addr_q;
    bt_valid_o   = 1'b0;
    bt_last_o    = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StSeq;
      end
      StSeq: begin
        seq_re_o = 1'b1;
        state_d  = seq_empty ? StFin : StEmit;
      end
      StEmit: begin
        bt_valid_o = 1'b1;
        bt_last_o  = last_c;
        if (bt_ready_i) state_d = last_c ? StFin : StFetch;
      end
      StFetch: begin
        ran_re_o     = 1'b1;
        ran_r_addr_o = prev_addr;
        state_d      = StEmit;
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bt_pos_o  = word_q[15:12];
  assign bt_addr_o = addr_q;
  assign bt_end_o  = word_q[0];
  assign err_o     = err_q;
  assign depth_o   = depth_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Walk datapath: current entry, depth counter, error flag, last random address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      addr_q     <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      ran_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            depth_q <= '0;
            err_q   <= 1'b0;
          end
        end
        StSeq: begin
          word_q <= seq_r_data_i;
          addr_q <= out_r_addr_i;
          if (seq_empty) err_q <= 1'b1;
        end
        StEmit: begin
          if (bt_ready_i) begin
            depth_q <= depth_q + 12'd1;
            if (last_c && !is_root) err_q <= 1'b1;
          end
        end
        StFetch: begin
          word_q     <= ran_r_data_i;
          addr_q     <= prev_addr;
          ran_addr_q <= prev_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_state_backtrace.sv
// Directed bench for state_backtrace: a small regfile model feeds two
// instances (default depth limit and MAX_DEPTH=2).
module tb_state_backtrace;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        bt_ready;
  logic [11:0] out_r_addr;
  logic [15:0] seq_r_data;
  logic [15:0] mem [16];

  logic        busy, seq_re, ran_re, bt_valid, bt_end, bt_last, done, err;
  logic [11:0] ran_r_addr, bt_addr, depth;
  logic [3:0]  bt_pos;
  logic [15:0] ran_r_data;

  logic        d2_busy, d2_seq_re, d2_ran_re, d2_bt_valid, d2_bt_end, d2_bt_last, d2_done, d2_err;
  logic [11:0] d2_ran_r_addr, d2_bt_addr, d2_depth;
  logic [3:0]  d2_bt_pos;
  logic [15:0] d2_ran_r_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign seq_r_data    = mem[out_r_addr[3:0]];
  assign ran_r_data    = mem[ran_r_addr[3:0]];
  assign d2_ran_r_data = mem[d2_ran_r_addr[3:0]];

  state_backtrace dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .seq_re_o(seq_re),
    .seq_r_data_i(seq_r_data), .out_r_addr_i(out_r_addr), .ran_re_o(ran_re),
    .ran_r_addr_o(ran_r_addr), .ran_r_data_i(ran_r_data), .bt_valid_o(bt_valid),
    .bt_ready_i(bt_ready), .bt_pos_o(bt_pos), .bt_addr_o(bt_addr), .bt_end_o(bt_end),
    .bt_last_o(bt_last), .done_o(done), .err_o(err), .depth_o(depth)
  );

  state_backtrace #(.MAX_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .busy_o(d2_busy), .seq_re_o(d2_seq_re),
    .seq_r_data_i(seq_r_data), .out_r_addr_i(out_r_addr), .ran_re_o(d2_ran_re),
    .ran_r_addr_o(d2_ran_r_addr), .ran_r_data_i(d2_ran_r_data), .bt_valid_o(d2_bt_valid),
    .bt_ready_i(bt_ready), .bt_pos_o(d2_bt_pos), .bt_addr_o(d2_bt_addr), .bt_end_o(d2_bt_end),
    .bt_last_o(d2_bt_last), .done_o(d2_done), .err_o(d2_err), .depth_o(d2_depth)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge where the DUT sits in SEQ.
  task automatic do_start(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    check("seq_re", sel ? d2_seq_re : seq_re, 1);
    check("ran_re_in_seq", sel ? d2_ran_re : ran_re, 0);
  endtask

  task automatic wait_valid(input bit sel, input string tag);
    for (int i = 0; i < 20 && !(sel ? d2_bt_valid : bt_valid); i++) @(negedge clk);
    check({tag, ".valid"}, sel ? d2_bt_valid : bt_valid, 1);
  endtask

  // Expects an entry, lets the handshake fire, returns at the following negedge.
  task automatic expect_emit(input bit sel, input string tag, input logic [11:0] a,
                             input logic [3:0] p, input logic e, input logic l);
    wait_valid(sel, tag);
    check({tag, ".addr"}, sel ? d2_bt_addr : bt_addr, a);
    check({tag, ".pos"},  sel ? d2_bt_pos  : bt_pos,  p);
    check({tag, ".end"},  sel ? d2_bt_end  : bt_end,  e);
    check({tag, ".last"}, sel ? d2_bt_last : bt_last, l);
    @(negedge clk);
  endtask

  task automatic load_chain();
    mem[0] = 16'h1FFE;  // pos 1, prev 7FF (root), end 0
    mem[1] = 16'h3000;  // pos 3, prev 0, end 0
    mem[2] = 16'h5003;  // pos 5, prev 1, end 1
    mem[3] = 16'h4004;  // pos 4, prev 2, end 0
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bt_ready = 1'b1; out_r_addr = 12'hFFF;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.outs", {bt_valid, done, err, seq_re, ran_re, depth}, 0);
    rst_n = 1'b1;

    // Empty regfile.
    do_start(1'b0);
    @(negedge clk);
    check("empty.done", done, 1);
    check("empty.valid", bt_valid, 0);
    check("empty.err", err, 1);
    check("empty.depth", depth, 0);
    @(negedge clk);
    check("empty.busy", busy, 0);

    // Three-entry chain with ready held high.
    load_chain();
    out_r_addr = 12'd2;
    do_start(1'b0);
    expect_emit(1'b0, "ch0", 12'd2, 4'd5, 1'b1, 1'b0);
    check("ch.ran_re", ran_re, 1);
    check("ch.ran_addr", ran_r_addr, 12'd1);
    expect_emit(1'b0, "ch1", 12'd1, 4'd3, 1'b0, 1'b0);
    expect_emit(1'b0, "ch2", 12'd0, 4'd1, 1'b0, 1'b1);
    check("ch.done", done, 1);
    check("ch.err", err, 0);
    check("ch.depth", depth, 3);
    check("ch.ran_hold", ran_r_addr, 12'd0);

    // Same chain, first entry stalled for five cycles.
    bt_ready = 1'b0;
    do_start(1'b0);
    wait_valid(1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      check("bp.hold", {bt_valid, bt_addr, bt_pos, bt_end, bt_last, ran_re},
            {1'b1, 12'd2, 4'd5, 1'b1, 1'b0, 1'b0});
      check("bp.depth", depth, 0);
      @(negedge clk);
    end
    bt_ready = 1'b1;
    expect_emit(1'b0, "bp0", 12'd2, 4'd5, 1'b1, 1'b0);
    expect_emit(1'b0, "bp1", 12'd1, 4'd3, 1'b0, 1'b0);
    expect_emit(1'b0, "bp2", 12'd0, 4'd1, 1'b0, 1'b1);
    check("bp.result", {done, err, depth}, {1'b1, 1'b0, 12'd3});

    // Self-referencing link.
    mem[3] = 16'h2006;  // pos 2, prev 3
    out_r_addr = 12'd3;
    do_start(1'b0);
    expect_emit(1'b0, "bad", 12'd3, 4'd2, 1'b0, 1'b1);
    check("bad.result", {done, err, depth}, {1'b1, 1'b1, 12'd1});

    // Depth limit of two on a four-deep chain.
    load_chain();
    do_start(1'b1);
    expect_emit(1'b1, "dl0", 12'd3, 4'd4, 1'b0, 1'b0);
    expect_emit(1'b1, "dl1", 12'd2, 4'd5, 1'b1, 1'b1);
    check("dl.result", {d2_done, d2_err, d2_depth}, {1'b1, 1'b1, 12'd2});

    // Reset in the middle of a fetch.
    out_r_addr = 12'd2;
    do_start(1'b0);
    expect_emit(1'b0, "rf0", 12'd2, 4'd5, 1'b1, 1'b0);
    check("rf.in_fetch", ran_re, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rf.zero", {busy, seq_re, ran_re, bt_valid, bt_last, done, err,
                      ran_r_addr, bt_pos, bt_addr, bt_end, depth}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1'b0);
    expect_emit(1'b0, "rs0", 12'd2, 4'd5, 1'b1, 1'b0);
    check("rs.depth", depth, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
